// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester identity,
// and the round-robin priority helper.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   typedef enum logic {OWNER_C = 1'b0, OWNER_E = 1'b1} arb_owner_e;

   function automatic arb_owner_e other_owner(input arb_owner_e o);
      return (o == OWNER_C) ? OWNER_E : OWNER_C;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// whichever requester currently holds priority.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic       c_req,
   input  logic       e_req,
   input  arb_owner_e prio,
   output logic       valid,
   output arb_owner_e winner
);

   always_comb begin
      valid = c_req | e_req;
      if (c_req && e_req) begin
         winner = prio;
      end else if (e_req) begin
         winner = OWNER_E;
      end else begin
         winner = OWNER_C;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core (C) and external (E) accesses onto one single-port data
// memory; read data is routed back only to the requester that issued it.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  e_req,
   input  logic                  e_we,
   input  logic [ADDR_WIDTH-1:0] e_addr,
   input  logic [DATA_WIDTH-1:0] e_wdata,
   output logic                  e_gnt,
   output logic                  e_rvalid,
   output logic [DATA_WIDTH-1:0] e_rdata,
   output logic                  m_re,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   arb_state_e            state_reg, state_next;
   arb_owner_e            owner_reg, owner_next;
   arb_owner_e            prio_reg, prio_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic                  m_re_reg, m_re_next;
   logic                  m_we_reg, m_we_next;
   logic [ADDR_WIDTH-1:0] m_addr_reg, m_addr_next;
   logic [DATA_WIDTH-1:0] m_wdata_reg, m_wdata_next;
   logic                  c_gnt_reg, c_gnt_next;
   logic                  e_gnt_reg, e_gnt_next;
   logic                  c_rvalid_reg, c_rvalid_next;
   logic                  e_rvalid_reg, e_rvalid_next;
   logic [DATA_WIDTH-1:0] c_rdata_reg, c_rdata_next;
   logic [DATA_WIDTH-1:0] e_rdata_reg, e_rdata_next;

   logic       pick_valid;
   arb_owner_e pick_winner;

   rr_pick2 u_pick (
      .c_req  (c_req),
      .e_req  (e_req),
      .prio   (prio_reg),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      prio_next     = prio_reg;
      cnt_next      = cnt_reg;
      m_re_next     = 1'b0;
      m_we_next     = 1'b0;
      m_addr_next   = m_addr_reg;
      m_wdata_next  = m_wdata_reg;
      c_gnt_next    = 1'b0;
      e_gnt_next    = 1'b0;
      c_rvalid_next = 1'b0;
      e_rvalid_next = 1'b0;
      c_rdata_next  = c_rdata_reg;
      e_rdata_next  = e_rdata_reg;

      case (state_reg)
         IDLE: begin
            // The winner's fields go straight into the memory-side registers,
            // so ISSUE presents them without another cycle of delay.
            if (pick_valid) begin
               owner_next = pick_winner;
               prio_next  = other_owner(pick_winner);
               state_next = ISSUE;
               if (pick_winner == OWNER_C) begin
                  m_we_next    = c_we;
                  m_re_next    = ~c_we;
                  m_addr_next  = c_addr;
                  m_wdata_next = c_wdata;
                  c_gnt_next   = 1'b1;
               end else begin
                  m_we_next    = e_we;
                  m_re_next    = ~e_we;
                  m_addr_next  = e_addr;
                  m_wdata_next = e_wdata;
                  e_gnt_next   = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (m_re_reg) begin
               state_next = WAIT;
               cnt_next   = CNT_W'(MEM_LATENCY - 1);
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               state_next = RESP;
               if (owner_reg == OWNER_C) begin
                  c_rvalid_next = 1'b1;
                  c_rdata_next  = m_rdata;
               end else begin
                  e_rvalid_next = 1'b1;
                  e_rdata_next  = m_rdata;
               end
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         owner_reg    <= OWNER_C;
         prio_reg     <= OWNER_C;
         cnt_reg      <= '0;
         m_re_reg     <= 1'b0;
         m_we_reg     <= 1'b0;
         m_addr_reg   <= '0;
         m_wdata_reg  <= '0;
         c_gnt_reg    <= 1'b0;
         e_gnt_reg    <= 1'b0;
         c_rvalid_reg <= 1'b0;
         e_rvalid_reg <= 1'b0;
         c_rdata_reg  <= '0;
         e_rdata_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         prio_reg     <= prio_next;
         cnt_reg      <= cnt_next;
         m_re_reg     <= m_re_next;
         m_we_reg     <= m_we_next;
         m_addr_reg   <= m_addr_next;
         m_wdata_reg  <= m_wdata_next;
         c_gnt_reg    <= c_gnt_next;
         e_gnt_reg    <= e_gnt_next;
         c_rvalid_reg <= c_rvalid_next;
         e_rvalid_reg <= e_rvalid_next;
         c_rdata_reg  <= c_rdata_next;
         e_rdata_reg  <= e_rdata_next;
      end
   end

   assign m_re     = m_re_reg;
   assign m_we     = m_we_reg;
   assign m_addr   = m_addr_reg;
   assign m_wdata  = m_wdata_reg;
   assign c_gnt    = c_gnt_reg;
   assign e_gnt    = e_gnt_reg;
   assign c_rvalid = c_rvalid_reg;
   assign e_rvalid = e_rvalid_reg;
   assign c_rdata  = c_rdata_reg;
   assign e_rdata  = e_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: instance 0 runs with MEM_LATENCY=1, instance 1 with
// MEM_LATENCY=2; the driver queues expected grant/response events per cycle.
module tb_dmem_arbiter;

   localparam int K_CW  = 0;
   localparam int K_CR  = 1;
   localparam int K_EW  = 2;
   localparam int K_ER  = 3;
   localparam int K_CRV = 4;
   localparam int K_ERV = 5;
   localparam int K_BAD = 9;

   typedef struct {
      int          inst;
      int          kind;
      int          at;
      logic [8:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        zero_win;
   logic        done;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   ev_t         exp_q[$];

   logic        c_req_a [2];
   logic        c_we_a [2];
   logic [8:0]  c_addr_a [2];
   logic [31:0] c_wdata_a [2];
   logic        c_gnt_a [2];
   logic        c_rvalid_a [2];
   logic [31:0] c_rdata_a [2];
   logic        e_req_a [2];
   logic        e_we_a [2];
   logic [8:0]  e_addr_a [2];
   logic [31:0] e_wdata_a [2];
   logic        e_gnt_a [2];
   logic        e_rvalid_a [2];
   logic [31:0] e_rdata_a [2];
   logic        m_re_a [2];
   logic        m_we_a [2];
   logic [8:0]  m_addr_a [2];
   logic [31:0] m_wdata_a [2];
   logic [31:0] m_rdata_a [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_val(input logic [8:0] a);
      return (a == 9'h1FF) ? 32'h12345678 : (32'hA5000000 | {23'd0, a});
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = gi + 1;
      logic [31:0] pipe [LAT];

      // Memory model: data for the address strobed with m_re appears LAT cycles later.
      always @(posedge clk) begin
         pipe[0] <= m_re_a[gi] ? mem_val(m_addr_a[gi]) : 32'hBAD0BAD0;
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign m_rdata_a[gi] = pipe[LAT-1];

      dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MEM_LATENCY(LAT)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .c_req    (c_req_a[gi]),
         .c_we     (c_we_a[gi]),
         .c_addr   (c_addr_a[gi]),
         .c_wdata  (c_wdata_a[gi]),
         .c_gnt    (c_gnt_a[gi]),
         .c_rvalid (c_rvalid_a[gi]),
         .c_rdata  (c_rdata_a[gi]),
         .e_req    (e_req_a[gi]),
         .e_we     (e_we_a[gi]),
         .e_addr   (e_addr_a[gi]),
         .e_wdata  (e_wdata_a[gi]),
         .e_gnt    (e_gnt_a[gi]),
         .e_rvalid (e_rvalid_a[gi]),
         .e_rdata  (e_rdata_a[gi]),
         .m_re     (m_re_a[gi]),
         .m_we     (m_we_a[gi]),
         .m_addr   (m_addr_a[gi]),
         .m_wdata  (m_wdata_a[gi]),
         .m_rdata  (m_rdata_a[gi])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int inst, input int kind, input int at,
                       input logic [8:0] addr, input logic [31:0] data);
      ev_t e;
      e.inst = inst; e.kind = kind; e.at = at; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic match(input int inst, input int kind, input logic [8:0] addr,
                        input logic [31:0] data);
      ev_t e;
      logic ok;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event inst=%0d cyc=%0d got kind=%0d addr=%h data=%h required no event",
                  inst, cyc, kind, addr, data);
         return;
      end
      e = exp_q.pop_front();
      ok = (e.inst == inst) && (e.kind == kind) && (e.at == cyc);
      if (kind <= K_ER && addr !== e.addr) ok = 1'b0;
      if ((kind == K_CW || kind == K_EW || kind == K_CRV || kind == K_ERV) && data !== e.data)
         ok = 1'b0;
      if (!ok) begin
         failures++;
         $display("FAIL event got inst=%0d kind=%0d cyc=%0d addr=%h data=%h required inst=%0d kind=%0d cyc=%0d addr=%h data=%h",
                  inst, kind, cyc, addr, data, e.inst, e.kind, e.at, e.addr, e.data);
      end else begin
         $display("txn inst=%0d kind=%0d cyc=%0d addr=%h data=%h ok", inst, kind, cyc, addr, data);
      end
   endtask

   // Monitor: every output pulse is matched against the head of the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (zero_win) begin
            checks++;
            if ({m_re_a[i], m_we_a[i], c_gnt_a[i], e_gnt_a[i], c_rvalid_a[i], e_rvalid_a[i]} !== 6'd0 ||
                m_addr_a[i] !== 9'd0 || m_wdata_a[i] !== 32'd0 ||
                c_rdata_a[i] !== 32'd0 || e_rdata_a[i] !== 32'd0) begin
               failures++;
               $display("FAIL outputs_zero inst=%0d cyc=%0d got strobes=%b%b%b%b%b%b addr=%h wdata=%h crdata=%h erdata=%h required all 0",
                        i, cyc, m_re_a[i], m_we_a[i], c_gnt_a[i], e_gnt_a[i], c_rvalid_a[i], e_rvalid_a[i],
                        m_addr_a[i], m_wdata_a[i], c_rdata_a[i], e_rdata_a[i]);
            end
         end
         checks++;
         if ((m_re_a[i] && m_we_a[i]) || (c_gnt_a[i] && e_gnt_a[i]) ||
             ((m_re_a[i] || m_we_a[i]) !== (c_gnt_a[i] || e_gnt_a[i]))) begin
            failures++;
            $display("FAIL exclusive inst=%0d cyc=%0d got m_re=%b m_we=%b c_gnt=%b e_gnt=%b required one strobe with one gnt",
                     i, cyc, m_re_a[i], m_we_a[i], c_gnt_a[i], e_gnt_a[i]);
         end
         if (c_gnt_a[i] === 1'b1)
            match(i, m_we_a[i] ? K_CW : (m_re_a[i] ? K_CR : K_BAD), m_addr_a[i], m_wdata_a[i]);
         if (e_gnt_a[i] === 1'b1)
            match(i, m_we_a[i] ? K_EW : (m_re_a[i] ? K_ER : K_BAD), m_addr_a[i], m_wdata_a[i]);
         if (c_rvalid_a[i] === 1'b1) match(i, K_CRV, 9'd0, c_rdata_a[i]);
         if (e_rvalid_a[i] === 1'b1) match(i, K_ERV, 9'd0, e_rdata_a[i]);
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending got %0d unseen events required 0", exp_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      int base;
      rst = 1'b0;
      zero_win = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         c_req_a[i] = 1'b0; c_we_a[i] = 1'b0; c_addr_a[i] = '0; c_wdata_a[i] = '0;
         e_req_a[i] = 1'b0; e_we_a[i] = 1'b0; e_addr_a[i] = '0; e_wdata_a[i] = '0;
      end

      // Reset held with a pending core write: nothing may be granted.
      c_req_a[0] = 1'b1; c_we_a[0] = 1'b1; c_addr_a[0] = 9'h055;
      c_req_a[1] = 1'b1; c_we_a[1] = 1'b1; c_addr_a[1] = 9'h055;
      zero_win = 1'b1;
      repeat (4) tick();
      zero_win = 1'b0;
      c_req_a[0] = 1'b0; c_req_a[1] = 1'b0;
      rst = 1'b1;
      tick();

      // Core write on the latency-2 instance.
      base = cyc;
      c_req_a[1] = 1'b1; c_we_a[1] = 1'b1; c_addr_a[1] = 9'h010; c_wdata_a[1] = 32'hDEADBEEF;
      push(1, K_CW, base + 1, 9'h010, 32'hDEADBEEF);
      tick();
      c_req_a[1] = 1'b0;
      tick();

      // External read, latency 2: response at cycle 4.
      base = cyc;
      e_req_a[1] = 1'b1; e_we_a[1] = 1'b0; e_addr_a[1] = 9'h1FF;
      push(1, K_ER, base + 1, 9'h1FF, 32'h0);
      push(1, K_ERV, base + 4, 9'h000, 32'h12345678);
      tick();
      e_req_a[1] = 1'b0;
      repeat (4) tick();

      // Both write continuously: C,E,C,E every two cycles, fields refreshed after each grant.
      base = cyc;
      c_req_a[1] = 1'b1; c_we_a[1] = 1'b1; c_addr_a[1] = 9'h020; c_wdata_a[1] = 32'h000000C0;
      e_req_a[1] = 1'b1; e_we_a[1] = 1'b1; e_addr_a[1] = 9'h030; e_wdata_a[1] = 32'h000000E0;
      push(1, K_CW, base + 1, 9'h020, 32'h000000C0);
      push(1, K_EW, base + 3, 9'h030, 32'h000000E0);
      push(1, K_CW, base + 5, 9'h020, 32'h000000C1);
      push(1, K_EW, base + 7, 9'h030, 32'h000000E1);
      repeat (2) tick();
      c_wdata_a[1] = 32'h000000C1;
      repeat (2) tick();
      e_wdata_a[1] = 32'h000000E1;
      repeat (3) tick();
      c_req_a[1] = 1'b0; e_req_a[1] = 1'b0;
      tick();

      // Reset pulse while a read waits: its response must never appear.
      base = cyc;
      c_req_a[1] = 1'b1; c_we_a[1] = 1'b0; c_addr_a[1] = 9'h040;
      push(1, K_CR, base + 1, 9'h040, 32'h0);
      tick();
      c_req_a[1] = 1'b0;
      tick();
      rst = 1'b0;
      zero_win = 1'b1;
      tick();
      rst = 1'b1;
      repeat (4) tick();
      zero_win = 1'b0;
      base = cyc;
      c_req_a[1] = 1'b1; c_we_a[1] = 1'b1; c_addr_a[1] = 9'h041; c_wdata_a[1] = 32'h5A5A5A5A;
      push(1, K_CW, base + 1, 9'h041, 32'h5A5A5A5A);
      tick();
      c_req_a[1] = 1'b0;
      tick();

      // Latency-1 instance: core read with c_req held -> rvalid at 3, next grant at 5.
      base = cyc;
      c_req_a[0] = 1'b1; c_we_a[0] = 1'b0; c_addr_a[0] = 9'h0AB;
      push(0, K_CR, base + 1, 9'h0AB, 32'h0);
      push(0, K_CRV, base + 3, 9'h000, 32'hA50000AB);
      push(0, K_CR, base + 5, 9'h0AB, 32'h0);
      push(0, K_CRV, base + 7, 9'h000, 32'hA50000AB);
      repeat (6) tick();
      c_req_a[0] = 1'b0;
      repeat (2) tick();

      // C won last, so priority sits with E: a tie now goes to E first.
      base = cyc;
      c_req_a[0] = 1'b1; c_we_a[0] = 1'b1; c_addr_a[0] = 9'h011; c_wdata_a[0] = 32'h11111111;
      e_req_a[0] = 1'b1; e_we_a[0] = 1'b1; e_addr_a[0] = 9'h022; e_wdata_a[0] = 32'h22222222;
      push(0, K_EW, base + 1, 9'h022, 32'h22222222);
      push(0, K_CW, base + 3, 9'h011, 32'h11111111);
      repeat (3) tick();
      c_req_a[0] = 1'b0; e_req_a[0] = 1'b0;
      repeat (3) tick();

      done = 1'b1;
      repeat (3) tick();
      $display("FAIL monitor did not finish the run");
      $fatal(1, "monitor stalled");
   end

endmodule
